conv_encoder_k3: RTL and testbench

Rate-1/2 convolutional encoder for the link's K=3 code, with generators G1=7 (111) and G2=5 (101). It is the transmit-side counterpart of the 4-state trellis decoder. The block accepts one data bit per handshake and emits one 2-bit parity symbol per bit. At the end of each frame it appends K-1=2 zero tail bits, so the trellis ends in state 00. An optional rate-2/3 puncturing mode marks erased parity bits on a separate mask, which the channel model turns into high-Z.

---
 rtl/conv_pkg.sv | 26 ++
 rtl/conv_encoder_k3.sv | 93 +++++++++
 tb/tb_conv_encoder_k3.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the K=3 rate-1/2 code: generators, trellis state
// encoding, puncture masks and the parity function used by encoder and decoder.
`timescale 1ns/1ps
package conv_pkg;

  localparam int K = 3;
  localparam logic [K-1:0] G1 = 3'b111;
  localparam logic [K-1:0] G2 = 3'b101;

  // Rate-2/3 erase masks, {phase1, phase0}; phase 1 drops p0
  localparam logic [3:0] PUNCT_R23 = 4'b01_00;

  typedef enum logic [1:0] {
    DATA  = 2'd0,
    TAIL0 = 2'd1,
    TAIL1 = 2'd2
  } state_t;

  // Taps ordered {u, s0, s1} so the MSB of each generator weights the new bit
  function automatic logic [1:0] conv_parity(input logic u, input logic [K-2:0] s);
    logic [K-1:0] taps;
    taps = {u, s[0], s[1]};
    return {^(taps & G1), ^(taps & G2)};
  endfunction

endpackage

// File: rtl/conv_encoder_k3.sv
// K=3 convolutional encoder with zero-tail termination and optional
// rate-2/3 puncturing reported on a per-bit erase mask.
`timescale 1ns/1ps
module conv_encoder_k3
  import conv_pkg::*;
#(
  parameter bit PUNCTURE = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       in_bit,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [1:0] parities,
  output logic [1:0] erase,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last
);

  state_t     state, state_nxt;
  logic [1:0] sreg;
  logic       phase;
  logic       slot_free;
  logic       encode;
  logic       enc_u;
  logic       enc_last;
  logic [1:0] emask;
  logic [1:0] par;

  assign slot_free = !out_valid || out_ready;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= DATA;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DATA:    if (in_valid && slot_free && in_last) state_nxt = TAIL0;
      TAIL0:   if (slot_free) state_nxt = TAIL1;
      TAIL1:   if (slot_free) state_nxt = DATA;
      default: state_nxt = DATA;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    encode   = 1'b0;
    enc_u    = 1'b0;
    enc_last = 1'b0;
    case (state)
      DATA: begin
        in_ready = slot_free;
        encode   = in_valid && slot_free;
        enc_u    = in_bit;
      end
      TAIL0: encode = slot_free;
      TAIL1: begin
        encode   = slot_free;
        enc_last = 1'b1;
      end
      default: ;
    endcase
  end

  assign emask = !PUNCTURE ? 2'b00 : (phase ? PUNCT_R23[3:2] : PUNCT_R23[1:0]);
  assign par   = conv_parity(enc_u, sreg);

  // Output register: a new encode overwrites the slot; otherwise it drains on out_ready
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      parities  <= 2'b00;
      erase     <= 2'b00;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
      sreg      <= 2'b00;
      phase     <= 1'b0;
    end else if (encode) begin
      parities  <= par & ~emask;
      erase     <= emask;
      out_last  <= enc_last;
      out_valid <= 1'b1;
      sreg      <= {sreg[0], enc_u};
      phase     <= enc_last ? 1'b0 : ~phase;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_encoder_k3.sv
// Scoreboard bench for conv_encoder_k3: one unpunctured and one punctured
// instance, directed frames with hand-derived symbol sequences.
`timescale 1ns/1ps
module tb_conv_encoder_k3;

  logic CLK = 1'b0;
  logic RST;
  logic in_bit, in_last, out_ready;
  logic in_valid0, in_valid1;
  logic in_ready0, in_ready1;
  logic [1:0] parities0, parities1, erase0, erase1;
  logic out_valid0, out_valid1, out_last0, out_last1;

  typedef struct packed {
    logic [1:0] par;
    logic [1:0] ers;
    logic       last;
  } sym_t;

  sym_t q0[$];
  sym_t q1[$];
  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  conv_encoder_k3 #(.PUNCTURE(1'b0)) u0 (
    .CLK(CLK), .RST(RST), .in_bit(in_bit), .in_valid(in_valid0), .in_last(in_last),
    .in_ready(in_ready0), .parities(parities0), .erase(erase0), .out_valid(out_valid0),
    .out_ready(out_ready), .out_last(out_last0)
  );

  conv_encoder_k3 #(.PUNCTURE(1'b1)) u1 (
    .CLK(CLK), .RST(RST), .in_bit(in_bit), .in_valid(in_valid1), .in_last(in_last),
    .in_ready(in_ready1), .parities(parities1), .erase(erase1), .out_valid(out_valid1),
    .out_ready(out_ready), .out_last(out_last1)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: every handshaken symbol must match the head of its queue
  always @(negedge CLK) begin
    sym_t e;
    if (!RST && out_valid0 && out_ready) begin
      if (q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL u0_unexpected: got %b expected no symbol", parities0);
      end else begin
        e = q0.pop_front();
        check("u0_sym", {3'b0, parities0, erase0, out_last0}, {3'b0, e});
      end
    end
  end

  always @(negedge CLK) begin
    sym_t e;
    if (!RST && out_valid1 && out_ready) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL u1_unexpected: got %b expected no symbol", parities1);
      end else begin
        e = q1.pop_front();
        check("u1_sym", {3'b0, parities1, erase1, out_last1}, {3'b0, e});
      end
    end
  end

  task automatic push(input int d, input logic [1:0] p, input logic [1:0] e, input logic l);
    sym_t s;
    s = '{par: p, ers: e, last: l};
    if (d == 0) q0.push_back(s);
    else        q1.push_back(s);
  endtask

  task automatic set_valid(input int d, input logic v);
    if (d == 0) in_valid0 = v;
    else        in_valid1 = v;
  endtask

  function automatic logic rdy(input int d);
    return (d == 0) ? in_ready0 : in_ready1;
  endfunction

  task automatic wait_accept(input int d);
    int t;
    t = 0;
    @(negedge CLK);
    while (!rdy(d) && t < 50) begin
      t++;
      @(negedge CLK);
    end
    if (!rdy(d)) begin
      checks++; failures++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
    end
    @(posedge CLK);
    #1;
  endtask

  // Hold out_ready low for three cycles with the next bit offered
  task automatic stall3(input int d, input logic b, input logic [1:0] held);
    out_ready = 1'b0;
    in_bit    = b;
    in_last   = 1'b0;
    set_valid(d, 1'b1);
    repeat (3) begin
      @(negedge CLK);
      check("stall_in_ready", {7'b0, in_ready0}, 8'h00);
      check("stall_out_valid", {7'b0, out_valid0}, 8'h01);
      check("stall_parities", {6'b0, parities0}, {6'b0, held});
    end
    @(posedge CLK);
    #1;
    out_ready = 1'b1;
  endtask

  task automatic send_bits(input int d, input logic [15:0] bits, input int n,
                           input int stall_at, input logic [1:0] held, input bit hold);
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) stall3(d, bits[i], held);
      in_bit  = bits[i];
      in_last = (i == n - 1);
      set_valid(d, 1'b1);
      wait_accept(d);
    end
    if (!hold) begin
      set_valid(d, 1'b0);
      in_last = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 100) begin
      @(posedge CLK);
      t++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout: got %0d/%0d pending expected 0", q0.size(), q1.size());
    end
    #1;
  endtask

  task automatic push_frame_1011(input int d);
    push(d, 2'b11, 2'b00, 1'b0);
    push(d, 2'b10, 2'b00, 1'b0);
    push(d, 2'b00, 2'b00, 1'b0);
    push(d, 2'b01, 2'b00, 1'b0);
    push(d, 2'b01, 2'b00, 1'b0);
    push(d, 2'b11, 2'b00, 1'b1);
  endtask

  initial begin
    RST = 1'b1; in_bit = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    in_valid0 = 1'b0; in_valid1 = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_out_valid", {7'b0, out_valid0}, 8'h00);
    check("rst_parities", {6'b0, parities0}, 8'h00);
    check("rst_erase", {6'b0, erase0}, 8'h00);
    check("rst_out_last", {7'b0, out_last0}, 8'h00);
    check("rst_in_ready", {7'b0, in_ready0}, 8'h01);
    check("rst_p_in_ready", {7'b0, in_ready1}, 8'h01);
    check("rst_p_erase", {6'b0, erase1}, 8'h00);
    RST = 1'b0;
    @(posedge CLK); #1;

    // Rate 1/2, frame 1,0,1,1
    push_frame_1011(0);
    send_bits(0, 16'b1101, 4, -1, 2'b00, 1'b0);
    drain();

    // Rate 2/3, same frame
    push(1, 2'b11, 2'b00, 1'b0);
    push(1, 2'b10, 2'b01, 1'b0);
    push(1, 2'b00, 2'b00, 1'b0);
    push(1, 2'b00, 2'b01, 1'b0);
    push(1, 2'b01, 2'b00, 1'b0);
    push(1, 2'b10, 2'b01, 1'b1);
    send_bits(1, 16'b1101, 4, -1, 2'b00, 1'b0);
    drain();

    // All-zero 8-bit frame: ten zero symbols
    for (int i = 0; i < 10; i++) push(0, 2'b00, 2'b00, i == 9);
    send_bits(0, 16'h0000, 8, -1, 2'b00, 1'b0);
    drain();

    // Back-pressure before bit 2; symbol 10 from bit 1 must hold
    push_frame_1011(0);
    send_bits(0, 16'b1101, 4, 2, 2'b10, 1'b0);
    drain();

    // in_valid held through the tail; next one-bit frame starts from s=00
    push_frame_1011(0);
    push(0, 2'b11, 2'b00, 1'b0);
    push(0, 2'b10, 2'b00, 1'b0);
    push(0, 2'b11, 2'b00, 1'b1);
    send_bits(0, 16'b1101, 4, -1, 2'b00, 1'b1);
    in_bit = 1'b1; in_last = 1'b1;
    begin
      int t;
      t = 0;
      @(negedge CLK);
      while (!(out_valid0 && out_last0) && t < 10) begin
        check("tail_in_ready", {7'b0, in_ready0}, 8'h00);
        t++;
        @(negedge CLK);
      end
      check("tail_last_seen", {7'b0, out_valid0 && out_last0}, 8'h01);
      check("tail_then_ready", {7'b0, in_ready0}, 8'h01);
    end
    @(posedge CLK); #1;
    in_valid0 = 1'b0; in_last = 1'b0;
    drain();

    // Reset during TAIL0 abandons the frame
    push_frame_1011(0);
    send_bits(0, 16'b1101, 4, -1, 2'b00, 1'b0);
    #1 RST = 1'b1;
    #1;
    check("rst_tail_out_valid", {7'b0, out_valid0}, 8'h00);
    check("rst_tail_in_ready", {7'b0, in_ready0}, 8'h01);
    check("rst_tail_parities", {6'b0, parities0}, 8'h00);
    check("rst_tail_out_last", {7'b0, out_last0}, 8'h00);
    check("rst_tail_dropped", q0.size(), 8'd3);
    q0.delete();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;
    push(0, 2'b11, 2'b00, 1'b0);
    push(0, 2'b10, 2'b00, 1'b0);
    push(0, 2'b11, 2'b00, 1'b1);
    send_bits(0, 16'b1, 1, -1, 2'b00, 1'b0);
    drain();

    repeat (3) @(posedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
